// File: rtl/fnd_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package fnd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } fnd_state_t;

   localparam logic [7:0] FONT_BLANK = 8'hFF;

   // Active-low segment codes {dp,g,f,e,d,c,b,a}; dp bit stays 1 (off).
   function automatic logic [7:0] seg_font(input logic [3:0] digit);
      logic [7:0] code;
      case (digit)
         4'd0:    code = 8'hC0;
         4'd1:    code = 8'hF9;
         4'd2:    code = 8'hA4;
         4'd3:    code = 8'hB0;
         4'd4:    code = 8'h99;
         4'd5:    code = 8'h92;
         4'd6:    code = 8'h82;
         4'd7:    code = 8'hF8;
         4'd8:    code = 8'h80;
         4'd9:    code = 8'h90;
         default: code = FONT_BLANK;
      endcase
      return code;
   endfunction

   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter; one shift per cycle, VALUE_W shifts.
module fnd_bin2bcd
   import fnd_pkg::*;
#(
   parameter int VALUE_W    = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [VALUE_W-1:0]      bin,
   output logic                    done,
   output logic [NUM_DIGITS*4-1:0] bcd
);

   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int CNT_W = clog2_min1(VALUE_W + 1);

   logic [VALUE_W-1:0] sh;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   adj;

   always_comb begin
      adj = bcd;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh  <= '0;
         bcd <= '0;
         cnt <= '0;
      end else if (start) begin
         sh  <= bin;
         bcd <= '0;
         cnt <= CNT_W'(VALUE_W);
      end else if (cnt != '0) begin
         {bcd, sh} <= {adj, sh} << 1;
         cnt       <= cnt - 1'b1;
      end
   end

   // High during the cycle whose closing edge performs the final shift.
   assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/fnd_scan_controller.sv
// N-digit multiplexed FND driver: load/convert/commit FSM plus free-running digit scan.
// Optional build macro FND_LZ_BLANK_EN blanks leading zeros (digit 0 is never blanked).
//
// state  | meaning
// IDLE   | display stable, waiting for i_load
// CONV   | converter shifting, one bit per cycle
// COMMIT | BCD result and overflow flag copied to the display register
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int VALUE_W        = 14,
   parameter int CLK_HZ         = 100_000_000,
   parameter int SCAN_HZ        = 1_000,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [VALUE_W-1:0]    i_value,
   input  logic                  i_load,
   input  logic                  i_disp_en,
   output logic                  o_busy,
   output logic                  o_overflow,
   output logic [NUM_DIGITS-1:0] o_fndSelect,
   output logic [7:0]            o_fndFont
);

   localparam int          TICK_DIV = CLK_HZ / SCAN_HZ;
   localparam int          PRE_W    = clog2_min1(TICK_DIV);
   localparam int          IDX_W    = clog2_min1(NUM_DIGITS);
   localparam int          BCD_W    = NUM_DIGITS * 4;
   localparam logic [63:0] MAX_VAL  = pow10(NUM_DIGITS) - 64'd1;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF =
      (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [7:0] FONT_OFF = (SEG_ACTIVE_LOW != 0) ? FONT_BLANK : ~FONT_BLANK;

   fnd_state_t         state;
   logic               pend_ovf;
   logic [BCD_W-1:0]   disp;
   logic               cap_ovf;
   logic [VALUE_W-1:0] cap_val;
   logic               conv_start;
   logic               conv_done;
   logic [BCD_W-1:0]   conv_bcd;
   logic [PRE_W-1:0]   presc;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         digit;
   logic               blank_digit;
   logic [7:0]         font_low;
   logic [NUM_DIGITS-1:0] sel_onehot;

   always_comb begin
      cap_ovf    = 64'(i_value) > MAX_VAL;
      cap_val    = cap_ovf ? MAX_VAL[VALUE_W-1:0] : i_value;
      conv_start = (state == IDLE) && i_load;
   end

   fnd_bin2bcd #(
      .VALUE_W    (VALUE_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk   (i_clk),
      .reset (i_reset),
      .start (conv_start),
      .bin   (cap_val),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         pend_ovf   <= 1'b0;
         disp       <= '0;
         o_busy     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_load) begin
                  pend_ovf <= cap_ovf;
                  o_busy   <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               if (conv_done) state <= COMMIT;
            end
            COMMIT: begin
               disp       <= conv_bcd;
               o_overflow <= pend_ovf;
               o_busy     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PRE_W'(TICK_DIV - 1)) begin
         presc <= '0;
         idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

`ifdef FND_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  upper_zero;

   // A digit is a leading zero when it and every higher digit are zero.
   always_comb begin
      lz_mask    = '0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (disp[4*k +: 4] == 4'd0);
         lz_mask[k] = upper_zero;
      end
      blank_digit = lz_mask[idx];
   end
`else
   assign blank_digit = 1'b0;
`endif

   always_comb begin
      digit      = disp[idx*4 +: 4];
      font_low   = blank_digit ? FONT_BLANK : seg_font(digit);
      sel_onehot = NUM_DIGITS'(1) << idx;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || !i_disp_en) begin
         o_fndSelect <= SEL_OFF;
         o_fndFont   <= FONT_OFF;
      end else begin
         o_fndSelect <= (SEL_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
         o_fndFont   <= (SEG_ACTIVE_LOW != 0) ? font_low : ~font_low;
      end
   end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: 4 digits, 14-bit value, tick every 4 cycles, active-low.
module tb_fnd_scan_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        en;
   logic [13:0] val;
   logic        busy;
   logic        ovf;
   logic [3:0]  sel;
   logic [7:0]  font;

   int n_cmp  = 0;
   int n_fail = 0;
   int ncyc   = 0;
   int nb;
   int bad;

`ifdef FND_LZ_BLANK_EN
   localparam logic [7:0] LZ = 8'hFF;
`else
   localparam logic [7:0] LZ = 8'hC0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) ncyc <= 0;
      else     ncyc <= ncyc + 1;
   end

   fnd_scan_controller #(
      .NUM_DIGITS     (4),
      .VALUE_W        (14),
      .CLK_HZ         (1000),
      .SCAN_HZ        (250),
      .SEL_ACTIVE_LOW (1),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_value     (val),
      .i_load      (load),
      .i_disp_en   (en),
      .o_busy      (busy),
      .o_overflow  (ovf),
      .o_fndSelect (sel),
      .o_fndFont   (font)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [13:0] v);
      val  = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Counts busy samples starting from the one right after the load edge.
   task automatic wait_idle(output int count);
      count = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         count++;
         tick();
      end
      chk("busy_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_digit(input string tag, input int idx, input logic [7:0] exp);
      logic [3:0] want;
      bit         found;
      want  = ~(4'b0001 << idx);
      found = 1'b0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (sel === want) begin
            found = 1'b1;
            break;
         end
      end
      chk({tag, "_sel"}, {31'd0, found}, 32'd1);
      chk(tag, {24'd0, font}, {24'd0, exp});
   endtask

   task automatic chk_disp(input string tag, input logic [7:0] f3, input logic [7:0] f2,
                           input logic [7:0] f1, input logic [7:0] f0);
      chk_digit({tag, "_d0"}, 0, f0);
      chk_digit({tag, "_d1"}, 1, f1);
      chk_digit({tag, "_d2"}, 2, f2);
      chk_digit({tag, "_d3"}, 3, f3);
   endtask

   function automatic logic [7:0] font_of_0005(input logic [3:0] s);
      case (s)
         4'b1110:                   return 8'h92;
         4'b1101, 4'b1011, 4'b0111: return LZ;
         default:                   return 8'hFF;
      endcase
   endfunction

   initial begin
      logic [7:0] f4321 [4];
      int         exp_idx;
      logic [3:0] exp_sel;
      f4321 = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

      rst  = 1'b1;
      load = 1'b0;
      en   = 1'b1;
      val  = '0;

      // Reset
      repeat (3) tick();
      chk("rst_sel",  {28'd0, sel}, 32'hF);
      chk("rst_font", {24'd0, font}, 32'hFF);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf",  {31'd0, ovf}, 32'd0);
      rst = 1'b0;
      tick();
      chk("scan_start_sel",  {28'd0, sel}, 32'b1110);
      chk("scan_start_font", {24'd0, font}, 32'hC0);

      // Load 1234
      do_load(14'd1234);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      wait_idle(nb);
      chk("busy_len", nb, 32'd15);
      chk("ovf_1234", {31'd0, ovf}, 32'd0);
      chk_disp("v1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

      // Overflow saturates to 9999, then a small value clears the flag
      do_load(14'd12000);
      wait_idle(nb);
      chk("ovf_set", {31'd0, ovf}, 32'd1);
      chk_disp("v9999", 8'h90, 8'h90, 8'h90, 8'h90);
      do_load(14'd5);
      wait_idle(nb);
      chk("ovf_clr", {31'd0, ovf}, 32'd0);
      chk_disp("v0005", LZ, LZ, LZ, 8'h92);

      // Load during busy is ignored; display holds 0005 until commit
      do_load(14'd4321);
      nb  = 0;
      bad = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         nb++;
         if (font !== font_of_0005(sel)) bad++;
         if (nb == 3) begin
            val  = 14'd9;
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
         tick();
      end
      load = 1'b0;
      chk("busy_len_ign", nb, 32'd15);
      chk("old_hold", bad, 32'd0);
      repeat (3) tick();
      chk("no_restart", {31'd0, busy}, 32'd0);
      chk_disp("v4321", 8'h99, 8'hB0, 8'hA4, 8'hF9);

      // Display disable: blank outputs, scan keeps running
      repeat (3) tick();
      en  = 1'b0;
      bad = 0;
      repeat (10) begin
         tick();
         if (sel !== 4'hF || font !== 8'hFF) bad++;
      end
      chk("dis_blank", bad, 32'd0);
      en = 1'b1;
      tick();
      exp_idx = ((ncyc - 1) / 4) % 4;
      exp_sel = ~(4'b0001 << exp_idx);
      chk("resume_sel",  {28'd0, sel}, {28'd0, exp_sel});
      chk("resume_font", {24'd0, font}, {24'd0, f4321[exp_idx]});

      // Leading zeros
      do_load(14'd7);
      wait_idle(nb);
      chk_disp("v0007", LZ, LZ, LZ, 8'hF8);
      do_load(14'd0);
      wait_idle(nb);
      chk_disp("v0000", LZ, LZ, LZ, 8'hC0);

      // Reset aborts a conversion
      do_load(14'd8888);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_sel",  {28'd0, sel}, 32'hF);
      chk("abort_font", {24'd0, font}, 32'hFF);
      rst = 1'b0;
      bad = 0;
      repeat (40) begin
         tick();
         if (font === 8'h80 || busy !== 1'b0) bad++;
      end
      chk("abort_no_commit", bad, 32'd0);
      chk("abort_ovf", {31'd0, ovf}, 32'd0);
      chk_digit("abort_d0", 0, 8'hC0);
      chk_digit("abort_d1", 1, LZ);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
